div_unit: RTL and testbench

- Multi-cycle integer divider. It is the responder side of the execute stage's divide handshake.
- Accepts dividend/divisor and a signed flag while start is held. It iterates one quotient bit per cycle with a restoring shift-subtract.
- Returns {remainder, quotient} for the HI/LO write with a ready flag. The execute stage stalls the pipeline until ready is seen.

---
 rtl/div_unit_pkg.sv | 21 ++
 rtl/div_unit_if.sv | 42 ++++
 rtl/div_step.sv | 29 ++
 rtl/div_unit.sv | 127 ++++++++++++
 tb/tb_div_unit.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared FSM state encoding and handshake level names for the
// multi-cycle divider (div_unit) and its execute-stage requester.
package div_unit_pkg;

  // 2-bit divider state encoding
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // start handshake levels
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  // ready flag levels
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: divide handshake between the execute stage (master) and the
// divider (slave).
//   signed_div_i : 1 = signed DIV, 0 = unsigned DIVU
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : held high by execute while it waits for the result
//   annul_i      : flush/exception abort (only when DIV_ANNUL_EN is defined)
//   result_o     : {remainder, quotient} for the HI/LO write
//   ready_o      : result valid
interface div_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
`ifdef DIV_ANNUL_EN
  logic                  annul_i;
`endif
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

`ifdef DIV_ANNUL_EN
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
`else
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i,
    input  result_o, ready_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i,
    output result_o, ready_o
  );
`endif
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring shift-subtract step.
//   partial_i : {rem, quo} before the step
//   divisor_i : divisor magnitude
//   partial_o : {rem, quo} after the step (new quotient bit in bit 0)
module div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] partial_i,
  input  logic [DATA_W-1:0]   divisor_i,
  output logic [2*DATA_W-1:0] partial_o
);

  logic [2*DATA_W:0] shifted;
  logic [DATA_W:0]   diff;

  // The remainder is always below the divisor, so the bit shifted out of the
  // top is only ever set when the trial subtract succeeds; a 2*DATA_W partial
  // with a (DATA_W+1)-bit trial window is therefore exact.
  always_comb begin
    shifted = {partial_i, 1'b0};
    diff    = shifted[2*DATA_W:DATA_W] - {1'b0, divisor_i};
    if (diff[DATA_W]) begin
      partial_o = shifted[2*DATA_W-1:0];
    end else begin
      partial_o = {diff[DATA_W-1:0], shifted[DATA_W-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring integer divider, responder side of the
// execute stage's divide handshake. One quotient bit per cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : div_unit_if.slave (operands, signed flag, start, result, ready)
// Build option: DIV_ANNUL_EN adds bus.annul_i, which aborts a division in
// progress (BYZERO/ON) back to FREE without producing a result.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic          clk,
  input  logic          rst,
  div_unit_if.slave     bus
);

  div_state_e            state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [2*DATA_W-1:0]   partial, partial_n;
  logic [DATA_W-1:0]     divisor, divisor_n;
  logic                  sign_a, sign_a_n;
  logic                  sign_b, sign_b_n;
  logic                  sdiv, sdiv_n;
  logic [2*DATA_W-1:0]   result, result_n;
  logic [2*DATA_W-1:0]   step_out;
  logic [DATA_W-1:0]     quo_fix, rem_fix;

  div_step #(.DATA_W(DATA_W)) u_step (
    .partial_i (partial),
    .divisor_i (divisor),
    .partial_o (step_out)
  );

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    partial_n = partial;
    divisor_n = divisor;
    sign_a_n  = sign_a;
    sign_b_n  = sign_b;
    sdiv_n    = sdiv;
    result_n  = result;
    quo_fix   = partial[DATA_W-1:0];
    rem_fix   = partial[2*DATA_W-1:DATA_W];

    case (state)
      DIV_FREE: begin
        result_n = '0;
        if (bus.start_i == DIV_START) begin
          sign_a_n  = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
          sign_b_n  = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
          sdiv_n    = bus.signed_div_i;
          partial_n = {{DATA_W{1'b0}},
                       magnitude(bus.opdata1_i, bus.signed_div_i & bus.opdata1_i[DATA_W-1])};
          divisor_n = magnitude(bus.opdata2_i, bus.signed_div_i & bus.opdata2_i[DATA_W-1]);
          cnt_n     = '0;
          state_n   = (bus.opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
        end
      end
      DIV_BY_ZERO: begin
        result_n = '0;
        state_n  = DIV_END;
      end
      DIV_ON: begin
        if (cnt != CNT_W'(DATA_W)) begin
          partial_n = step_out;
          cnt_n     = cnt + CNT_W'(1);
        end else begin
          // quotient negative on differing signs; remainder follows dividend
          if (sdiv && (sign_a ^ sign_b)) quo_fix = -partial[DATA_W-1:0];
          if (sdiv && sign_a)            rem_fix = -partial[2*DATA_W-1:DATA_W];
          result_n = {rem_fix, quo_fix};
          state_n  = DIV_END;
        end
      end
      DIV_END: begin
        if (bus.start_i == DIV_STOP) begin
          result_n = '0;
          state_n  = DIV_FREE;
        end
      end
      default: begin
        result_n = '0;
        state_n  = DIV_FREE;
      end
    endcase

`ifdef DIV_ANNUL_EN
    if (bus.annul_i && (state == DIV_ON || state == DIV_BY_ZERO)) begin
      result_n = '0;
      state_n  = DIV_FREE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DIV_FREE;
      cnt     <= '0;
      partial <= '0;
      divisor <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      sdiv    <= 1'b0;
      result  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      partial <= partial_n;
      divisor <= divisor_n;
      sign_a  <= sign_a_n;
      sign_b  <= sign_b_n;
      sdiv    <= sdiv_n;
      result  <= result_n;
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = (state == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  div_unit_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp_res;
    int          exp_lat;   // edges counted from (and including) the start-sampling edge
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncation toward zero, remainder takes
  // the dividend's sign; divide by zero yields all zeros.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint sa, sb, q, r;
    logic [31:0] q32, r32;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      q   = sa / sb;
      r   = sa % sb;
      q32 = 32'(q);
      r32 = 32'(r);
    end else begin
      q32 = a / b;
      r32 = a % b;
    end
    return {r32, q32};
  endfunction

  // Caller must be at a negedge. Raises start and waits (bounded) for ready.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [63:0] res, output int lat);
    bit ok;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = s;
    bus.start_i      = 1'b1;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("ready_timeout", 64'(ok), 64'd1);
    res = bus.result_o;
  endtask

  // Holds start for 'hold' cycles past ready, then drops it; ends at the negedge
  // after the edge that returns the divider to FREE.
  task automatic finish_div(input logic [63:0] exp, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_ready", 64'(bus.ready_o), 64'd1);
      check("hold_result", bus.result_o, exp);
    end
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("free_ready", 64'(bus.ready_o), 64'd0);
    check("free_result", bus.result_o, 64'd0);
  endtask

  initial begin
    vec_t        vecs[8];
    logic [63:0] res, exp;
    int          lat;
    logic [31:0] a, b;
    logic        s;
    bit          seen;

    vecs[0] = '{32'd100,        32'd7,          1'b0, {32'd2, 32'd14},                 34};
    vecs[1] = '{32'hFFFFFFF9,   32'd2,          1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD},    34};
    vecs[2] = '{32'd7,          32'hFFFFFFFE,   1'b1, {32'd1, 32'hFFFFFFFD},           34};
    vecs[3] = '{32'd5,          32'd0,          1'b0, 64'd0,                           2};
    vecs[4] = '{32'hFFFFFFFF,   32'd16,         1'b0, {32'd15, 32'h0FFFFFFF},          34};
    vecs[5] = '{32'h80000000,   32'hFFFFFFFF,   1'b1, {32'd0, 32'h80000000},           34};
    vecs[6] = '{32'h80000000,   32'hFFFFFFFF,   1'b0, {32'h80000000, 32'd0},           34};
    vecs[7] = '{32'hFFFFFFF9,   32'd0,          1'b1, 64'd0,                           2};

    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
`ifdef DIV_ANNUL_EN
    bus.annul_i      = 1'b0;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // directed table; each follows the previous after exactly one FREE cycle
    for (int i = 0; i < 8; i++) begin
      run_div(vecs[i].a, vecs[i].b, vecs[i].s, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      finish_div(vecs[i].exp_res, 4);
    end

    // start dropped right after sampling, operands scrambled: still completes
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd7;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i      = 1'b0;
    bus.opdata1_i    = 32'hDEADBEEF;
    bus.opdata2_i    = 32'd3;
    bus.signed_div_i = 1'b1;
    seen = 1'b0;
    lat  = 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.ready_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("drop_ready_seen", 64'(seen), 64'd1);
    check("drop_latency", 64'(lat), 64'd34);
    check("drop_result", bus.result_o, {32'd6, 32'd142});
    @(posedge clk);
    @(negedge clk);
    check("drop_end_left", 64'(bus.ready_o), 64'd0);
    check("drop_end_result", bus.result_o, 64'd0);

    // reset at iteration 10 aborts with no result
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst         = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_abort_ready", 64'(bus.ready_o), 64'd0);
    check("rst_abort_result", bus.result_o, 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready_o) seen = 1'b1;
    end
    check("rst_no_late_ready", 64'(seen), 64'd0);
    run_div(32'd9, 32'd3, 1'b0, res, lat);
    check("post_rst_result", res, {32'd0, 32'd3});
    check("post_rst_latency", 64'(lat), 64'd34);
    finish_div({32'd0, 32'd3}, 0);

`ifdef DIV_ANNUL_EN
    // annul at iteration 5 drops back to FREE with no result
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
    check("annul_ready", 64'(bus.ready_o), 64'd0);
    check("annul_result", bus.result_o, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready_o) seen = 1'b1;
    end
    check("annul_no_ready", 64'(seen), 64'd0);
    run_div(32'd9, 32'd3, 1'b0, res, lat);
    check("post_annul_result", res, {32'd0, 32'd3});
    finish_div({32'd0, 32'd3}, 0);
`endif

    // randomized operands against the reference
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 20);
        3:       b = -($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 255);
      s   = 1'($urandom_range(0, 1));
      exp = model(a, b, s);
      run_div(a, b, s, res, lat);
      check($sformatf("rand%0d_result a=%h b=%h s=%0d", i, a, b, s), res, exp);
      check($sformatf("rand%0d_latency", i), 64'(lat), (b == 32'd0) ? 64'd2 : 64'd34);
      finish_div(exp, i % 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
